// File: rtl/btn_debounce_events.sv
// Per-channel button debouncer: 2-FF synchronizer, debounce FSM and press/release/auto-repeat
// event pulses. Every channel is an independent copy of the same logic.
module btn_debounce_events #(
   parameter int NUM_BTN         = 3,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int REPEAT_EN       = 1,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_repeat
);

   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RCNT_W = $clog2(REPEAT_DELAY + 1);

   localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]  CNT_DONE    = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [RCNT_W-1:0] RCNT_ONE    = RCNT_W'(1);
   localparam logic [RCNT_W-1:0] RCNT_MAX    = RCNT_W'(REPEAT_DELAY);
   localparam logic [RCNT_W-1:0] RCNT_FIRE   = RCNT_W'(REPEAT_DELAY - 1);
   localparam logic [RCNT_W-1:0] RCNT_RELOAD = RCNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CONF_PRESS = 2'd1,
      HELD       = 2'd2,
      CONF_REL   = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (v >= CNT_DONE) ? CNT_DONE : v + CNT_ONE;
   endfunction

   function automatic logic [RCNT_W-1:0] sat_inc_rcnt(input logic [RCNT_W-1:0] v);
      return (v >= RCNT_MAX) ? RCNT_MAX : v + RCNT_ONE;
   endfunction

   logic [NUM_BTN-1:0] sync_p0;
   logic [NUM_BTN-1:0] sync_p1;

   // Stage p0/p1: raw pins into the two-flop synchronizer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      state_t            state;
      state_t            state_nx;
      logic [CNT_W-1:0]  cnt;
      logic [CNT_W-1:0]  cnt_nx;
      logic [RCNT_W-1:0] rcnt;
      logic [RCNT_W-1:0] rcnt_nx;
      logic [RCNT_W-1:0] rcnt_run;
      logic              rep_due;
      logic              s;
      logic              level_q;
      logic              press_q;
      logic              release_q;
      logic              repeat_q;
      logic              level_nx;
      logic              press_nx;
      logic              release_nx;
      logic              repeat_nx;

      assign s = sync_p1[i];

      // Stage p2: FSM state, counters and registered event outputs
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
         end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rcnt      <= rcnt_nx;
            level_q   <= level_nx;
            press_q   <= press_nx;
            release_q <= release_nx;
            repeat_q  <= repeat_nx;
         end
      end

      always_comb begin
         state_nx   = state;
         cnt_nx     = cnt;
         rcnt_nx    = rcnt;
         level_nx   = level_q;
         press_nx   = 1'b0;
         release_nx = 1'b0;
         repeat_nx  = 1'b0;

         // Fire on the cycle rcnt would reach REPEAT_DELAY so the pulse lands
         // exactly REPEAT_DELAY cycles after the press pulse.
         rep_due  = (REPEAT_EN != 0) && (rcnt == RCNT_FIRE);
         rcnt_run = rep_due ? RCNT_RELOAD : sat_inc_rcnt(rcnt);

         case (state)
            IDLE: begin
               rcnt_nx = '0;
               if (s) begin
                  state_nx = CONF_PRESS;
                  cnt_nx   = CNT_ONE;
               end
            end
            CONF_PRESS: begin
               if (!s) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (cnt == CNT_DONE) begin
                  state_nx = HELD;
                  cnt_nx   = '0;
                  rcnt_nx  = '0;
                  level_nx = 1'b1;
                  press_nx = 1'b1;
               end else begin
                  cnt_nx = sat_inc_cnt(cnt);
               end
            end
            HELD: begin
               rcnt_nx   = rcnt_run;
               repeat_nx = rep_due;
               if (!s) begin
                  state_nx = CONF_REL;
                  cnt_nx   = CNT_ONE;
               end
            end
            CONF_REL: begin
               if (s) begin
                  state_nx  = HELD;
                  cnt_nx    = '0;
                  rcnt_nx   = rcnt_run;
                  repeat_nx = rep_due;
               end else if (cnt == CNT_DONE) begin
                  // Release takes priority over a repeat due in the same cycle
                  state_nx   = IDLE;
                  cnt_nx     = '0;
                  rcnt_nx    = '0;
                  level_nx   = 1'b0;
                  release_nx = 1'b1;
               end else begin
                  cnt_nx    = sat_inc_cnt(cnt);
                  rcnt_nx   = rcnt_run;
                  repeat_nx = rep_due;
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
               rcnt_nx  = '0;
               level_nx = 1'b0;
            end
         endcase
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;
      assign btn_repeat[i]  = repeat_q;
   end

endmodule

// File: tb/tb_btn_debounce_events.sv
// Bench for btn_debounce_events: expected event pulses are queued with their cycle when
// stimulus is applied and compared every cycle by a monitor; a second, slower instance runs the long profile.
module tb_btn_debounce_events;

   localparam int D   = 8;
   localparam int R   = 20;
   localparam int PER = 10;
   // Default timing scaled by 1/1000 (1 ms = 50 cycles)
   localparam int DB  = 250;
   localparam int RB  = 25000;
   localparam int PB  = 5000;
   localparam int MS  = 50;

   logic       clk;
   logic       rst_n;
   logic [2:0] btn_raw;
   logic [2:0] btn_level, btn_press, btn_release, btn_repeat;
   logic [2:0] btn_raw_b;
   logic [2:0] btn_level_b, btn_press_b, btn_release_b, btn_repeat_b;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [2:0] mask;
   } ev_t;

   ev_t press_q[$], rel_q[$], rep_q[$];
   ev_t press_qb[$], rel_qb[$], rep_qb[$];
   ev_t mon_e;
   logic [2:0] exp_m;

   btn_debounce_events #(
      .NUM_BTN(3), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1),
      .REPEAT_DELAY(R), .REPEAT_PERIOD(PER)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press),
      .btn_release(btn_release), .btn_repeat(btn_repeat)
   );

   btn_debounce_events #(
      .NUM_BTN(3), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
      .REPEAT_DELAY(RB), .REPEAT_PERIOD(PB)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw_b),
      .btn_level(btn_level_b), .btn_press(btn_press_b),
      .btn_release(btn_release_b), .btn_repeat(btn_repeat_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic ev_t mk(input int c, input logic [2:0] m);
      ev_t e;
      e.cyc  = c;
      e.mask = m;
      return e;
   endfunction

   task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Every cycle each pulse output must equal whatever the scoreboard has due now (else 0)
   always @(negedge clk) begin
      exp_m = 3'b000;
      if (press_q.size() > 0 && press_q[0].cyc == cyc) begin mon_e = press_q.pop_front(); exp_m = mon_e.mask; end
      check("press", btn_press, exp_m);
      exp_m = 3'b000;
      if (rel_q.size() > 0 && rel_q[0].cyc == cyc) begin mon_e = rel_q.pop_front(); exp_m = mon_e.mask; end
      check("release", btn_release, exp_m);
      exp_m = 3'b000;
      if (rep_q.size() > 0 && rep_q[0].cyc == cyc) begin mon_e = rep_q.pop_front(); exp_m = mon_e.mask; end
      check("repeat", btn_repeat, exp_m);
      exp_m = 3'b000;
      if (press_qb.size() > 0 && press_qb[0].cyc == cyc) begin mon_e = press_qb.pop_front(); exp_m = mon_e.mask; end
      check("press_b", btn_press_b, exp_m);
      exp_m = 3'b000;
      if (rel_qb.size() > 0 && rel_qb[0].cyc == cyc) begin mon_e = rel_qb.pop_front(); exp_m = mon_e.mask; end
      check("release_b", btn_release_b, exp_m);
      exp_m = 3'b000;
      if (rep_qb.size() > 0 && rep_qb[0].cyc == cyc) begin mon_e = rep_qb.pop_front(); exp_m = mon_e.mask; end
      check("repeat_b", btn_repeat_b, exp_m);
      check("repeat_excl", btn_repeat & (btn_press | btn_release), 3'b000);
   end

   initial begin
      int p;
      rst_n     = 1'b0;
      btn_raw   = 3'b000;
      btn_raw_b = 3'b000;
      step(3);
      #1;
      check("rst_level",   btn_level,   3'b000);
      check("rst_press",   btn_press,   3'b000);
      check("rst_release", btn_release, 3'b000);
      check("rst_repeat",  btn_repeat,  3'b000);
      check("rst_level_b", btn_level_b, 3'b000);
      step(1);
      rst_n = 1'b1;
      step(2);

      // 1: single press on channel 0, then release
      btn_raw = 3'b001;
      press_q.push_back(mk(cyc + D + 3, 3'b001));
      step(D + 3);
      step(2);
      check("s1_level_hi", btn_level, 3'b001);
      btn_raw = 3'b000;
      rel_q.push_back(mk(cyc + D + 3, 3'b001));
      step(D + 5);
      check("s1_level_lo", btn_level, 3'b000);

      // 2: bouncing channel 1, short highs give nothing
      for (int k = 0; k < 4; k++) begin
         btn_raw[1] = 1'b1;
         step(5);
         btn_raw[1] = 1'b0;
         step(5);
      end
      check("s2_bounce_level", btn_level, 3'b000);
      btn_raw[1] = 1'b1;
      press_q.push_back(mk(cyc + D + 3, 3'b010));
      step(D + 5);
      check("s2_level_hi", btn_level, 3'b010);
      btn_raw[1] = 1'b0;
      rel_q.push_back(mk(cyc + D + 3, 3'b010));
      step(D + 5);
      check("s2_level_lo", btn_level, 3'b000);

      // 3: long hold on channel 2; the release coincides with a due repeat and wins
      btn_raw[2] = 1'b1;
      p = cyc + D + 3;
      press_q.push_back(mk(p, 3'b100));
      for (int k = 0; k < 5; k++) rep_q.push_back(mk(p + R + k * PER, 3'b100));
      step(D + 3 + 59);
      check("s3_level_hi", btn_level, 3'b100);
      btn_raw[2] = 1'b0;
      rel_q.push_back(mk(cyc + D + 3, 3'b100));
      step(D + 3);
      step(PER + 5);
      check("s3_level_lo", btn_level, 3'b000);

      // 4: channels 0 and 2 together, 7-cycle release glitch on channel 0
      btn_raw = 3'b101;
      p = cyc + D + 3;
      press_q.push_back(mk(p, 3'b101));
      rep_q.push_back(mk(p + R, 3'b101));
      step(D + 5);
      btn_raw[0] = 1'b0;
      step(7);
      btn_raw[0] = 1'b1;
      check("s4_glitch_level", btn_level, 3'b101);
      step(1);
      btn_raw = 3'b000;
      rel_q.push_back(mk(cyc + D + 3, 3'b101));
      step(D + 5);
      check("s4_level_lo", btn_level, 3'b000);

      // 5: reset during CONF_PRESS and during HELD
      btn_raw = 3'b001;
      step(5);
      rst_n = 1'b0;
      #1;
      check("s5a_rst_level",   btn_level,   3'b000);
      check("s5a_rst_press",   btn_press,   3'b000);
      check("s5a_rst_release", btn_release, 3'b000);
      check("s5a_rst_repeat",  btn_repeat,  3'b000);
      step(3);
      rst_n = 1'b1;
      press_q.push_back(mk(cyc + D + 3, 3'b001));
      step(D + 5);
      check("s5_held_level", btn_level, 3'b001);
      rst_n = 1'b0;
      #1;
      check("s5b_rst_level",   btn_level,   3'b000);
      check("s5b_rst_press",   btn_press,   3'b000);
      check("s5b_rst_release", btn_release, 3'b000);
      check("s5b_rst_repeat",  btn_repeat,  3'b000);
      step(3);
      rst_n = 1'b1;
      press_q.push_back(mk(cyc + D + 3, 3'b001));
      step(D + 5);
      check("s5_repress_level", btn_level, 3'b001);
      btn_raw = 3'b000;
      rel_q.push_back(mk(cyc + D + 3, 3'b001));
      step(D + 5);
      check("s5_level_lo", btn_level, 3'b000);

      // 6: slow instance, bench profile high/low/high/low then long hold
      for (int k = 0; k < 2; k++) begin
         btn_raw_b[0] = 1'b1;
         step(MS);
         btn_raw_b[0] = 1'b0;
         step(MS);
      end
      check("s6_bounce_level", btn_level_b, 3'b000);
      btn_raw_b[0] = 1'b1;
      press_qb.push_back(mk(cyc + DB + 3, 3'b001));
      step(10 * MS);
      check("s6_level_hi", btn_level_b, 3'b001);
      btn_raw_b[0] = 1'b0;
      rel_qb.push_back(mk(cyc + DB + 3, 3'b001));
      step(DB + 10);
      check("s6_level_lo", btn_level_b, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
